// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, fetches over an imem req/ack handshake, issues to the decoder.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int unsigned       TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [ADDR_W-1:0] pc,
  input  logic              jump,
  input  logic              branch,
  input  logic              zero,
  output logic              fetch_fault
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_ISSUE,
    ST_RESOLVE
`ifdef FETCH_TIMEOUT_EN
    , ST_FAULT
`endif
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc4;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] next_pc;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;
`endif

  assign imem_addr = pc;
  assign opcode    = instr[31:26];

  // Redirect target, evaluated while the decoder's answer is valid in RESOLVE.
  always_comb begin
    pc4    = pc + ADDR_W'(4);
    br_off = ADDR_W'($signed({instr[15:0], 2'b00}));
    if (jump)
      next_pc = {pc4[ADDR_W-1:28], instr[25:0], 2'b00};
    else if (branch && zero)
      next_pc = pc4 + br_off;
    else
      next_pc = pc4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
`ifdef FETCH_TIMEOUT_EN
      fetch_fault <= 1'b0;
      wait_cnt    <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          state    <= ST_REQ;
          imem_req <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ST_REQ, ST_WAIT: begin
          // An ack on the limit cycle takes priority over the watchdog.
          if (imem_ack) begin
            instr       <= imem_rdata;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= ST_ISSUE;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            imem_req    <= 1'b0;
            fetch_fault <= 1'b1;
            state       <= ST_FAULT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            state    <= ST_WAIT;
          end
`else
          else begin
            state <= ST_WAIT;
          end
`endif
        end
        ST_ISSUE: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= ST_RESOLVE;
          end
        end
        ST_RESOLVE: begin
          pc       <= next_pc;
          imem_req <= 1'b1;
          state    <= ST_REQ;
`ifdef FETCH_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
`ifdef FETCH_TIMEOUT_EN
        ST_FAULT: begin
          state <= ST_FAULT;
        end
`endif
        default: begin
          state       <= ST_IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

`ifndef FETCH_TIMEOUT_EN
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: randomized fetch/issue/redirect traffic against a PC model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack, instr_valid, instr_ready, jump, branch, zero, fetch_fault;
  logic [31:0] imem_addr, imem_rdata, instr, pc;
  logic [5:0]  opcode;

  logic        h_rst_n, h_req, h_ack, h_valid, h_ready, h_jump, h_branch, h_zero, h_fault;
  logic [31:0] h_addr, h_rdata, h_instr, h_pc;
  logic [5:0]  h_opcode;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_pc;

  logic [31:0] f_addr, f_instr;
  logic [5:0]  f_opc;
  int unsigned f_reqc, f_validc;
  bit          f_astab, f_istab, f_tmo, f_dup;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .TIMEOUT_CYC(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .opcode(opcode), .pc(pc), .jump(jump), .branch(branch), .zero(zero), .fetch_fault(fetch_fault)
  );

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h2000_0000), .TIMEOUT_CYC(16)) u_dut_hi (
    .clk(clk), .rst_n(h_rst_n), .imem_req(h_req), .imem_addr(h_addr), .imem_ack(h_ack),
    .imem_rdata(h_rdata), .instr_valid(h_valid), .instr_ready(h_ready), .instr(h_instr),
    .opcode(h_opcode), .pc(h_pc), .jump(h_jump), .branch(h_branch), .zero(h_zero), .fetch_fault(h_fault)
  );

  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] word,
                                           input logic j, input logic b, input logic z);
    logic [31:0] pc4;
    int          off;
    pc4 = cur + 32'd4;
    if (j) return (pc4 & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
    if (b && z) begin
      off = $signed(word[15:0]);
      return pc4 + 32'(off * 4);
    end
    return pc4;
  endfunction

  // One full fetch/issue/resolve transaction; entered and left on a negedge.
  task automatic do_fetch(input logic [31:0] word, input int unsigned ack_dly, input int unsigned rdy_dly,
                          input logic j, input logic b, input logic z);
    int unsigned n;
    f_tmo = 0; f_dup = 0; f_astab = 1; f_istab = 1; f_reqc = 0; f_validc = 0;
    n = 0;
    while (imem_req !== 1'b1) begin
      if (instr_valid === 1'b1) f_dup = 1;
      @(negedge clk); n++;
      if (n > 60) begin f_tmo = 1; return; end
    end
    f_addr = imem_addr;
    n = 0;
    while (imem_req === 1'b1) begin
      if (imem_addr !== f_addr) f_astab = 0;
      imem_ack   = (n == ack_dly);
      imem_rdata = imem_ack ? word : $urandom;
      @(negedge clk); n++;
      imem_ack = 1'b0;
      if (n > 60) begin f_tmo = 1; return; end
    end
    f_reqc  = n;
    f_instr = instr;
    f_opc   = opcode;
    n = 0;
    while (instr_valid === 1'b1) begin
      if (instr !== f_instr) f_istab = 0;
      instr_ready = (n == rdy_dly);
      imem_ack    = 1'($urandom_range(0, 1));
      imem_rdata  = $urandom;
      jump = 1'($urandom); branch = 1'($urandom); zero = 1'($urandom);
      @(negedge clk); n++;
      instr_ready = 1'b0; imem_ack = 1'b0;
      if (n > 60) begin f_tmo = 1; return; end
    end
    f_validc = n;
    jump = j; branch = b; zero = z;
    @(negedge clk);
    jump = 1'($urandom); branch = 1'($urandom); zero = 1'($urandom);
  endtask

  task automatic advance_to(input logic [31:0] target);
    logic [31:0] w;
    for (int unsigned k = 0; k < 16 && m_pc != target; k++) begin
      w = $urandom;
      do_fetch(w, 0, 0, 1'b0, 1'b0, 1'b0);
      if (f_tmo || f_addr !== m_pc) begin
        errors++; $display("FAIL advance_addr: got %h expected %h (tmo=%0d)", f_addr, m_pc, f_tmo);
      end
      checks++;
      m_pc = ref_next(m_pc, w, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    checks++;
    if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", instr); end
    checks++;
    if (pc !== 32'h0 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_pc: got %h/%h expected 0", pc, imem_addr);
    end
    checks++;
    if (fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", fetch_fault); end
    checks++;
    rst_n = 1'b1;
    m_pc  = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_fetch(32'h8C08_0004, 0, 0, 1'b0, 1'b0, 1'b0);
    if (f_tmo || f_addr !== 32'h0) begin errors++; $display("FAIL basic_addr: got %h expected 0", f_addr); end
    checks++;
    if (f_reqc != 1) begin errors++; $display("FAIL basic_req_cycles: got %0d expected 1", f_reqc); end
    checks++;
    if (f_opc !== 6'b100011) begin errors++; $display("FAIL basic_opcode: got %b expected 100011", f_opc); end
    checks++;
    if (f_instr !== 32'h8C08_0004) begin errors++; $display("FAIL basic_instr: got %h expected 8c080004", f_instr); end
    checks++;
    if (f_validc != 1) begin errors++; $display("FAIL basic_valid_cycles: got %0d expected 1", f_validc); end
    checks++;
    m_pc = ref_next(m_pc, 32'h8C08_0004, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_ack_delay();
    do_fetch(32'hAC09_0008, 5, 0, 1'b0, 1'b0, 1'b0);
    if (f_tmo || f_addr !== 32'h4) begin errors++; $display("FAIL delay_addr: got %h expected 4", f_addr); end
    checks++;
    if (f_reqc != 6 || !f_astab) begin
      errors++; $display("FAIL delay_req_hold: got %0d cycles stable=%0d expected 6 stable=1", f_reqc, f_astab);
    end
    checks++;
    if (f_validc != 1 || f_instr !== 32'hAC09_0008) begin
      errors++; $display("FAIL delay_issue: got %0d/%h expected 1/ac090008", f_validc, f_instr);
    end
    checks++;
    m_pc = ref_next(m_pc, 32'hAC09_0008, 1'b0, 1'b0, 1'b0);
    do_fetch(32'h0, 0, 0, 1'b0, 1'b0, 1'b0);
    if (f_dup || f_addr !== 32'h8) begin
      errors++; $display("FAIL delay_no_dup: got addr %h dup=%0d expected 8 dup=0", f_addr, f_dup);
    end
    checks++;
    m_pc = ref_next(m_pc, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_branch();
    for (int unsigned pass = 0; pass < 2; pass++) begin
      advance_to(32'h10);
      do_fetch(32'h1000_FFFC, 0, 0, 1'b0, 1'b1, (pass == 0));
      if (f_tmo || f_addr !== 32'h10) begin errors++; $display("FAIL beq_at: got %h expected 10", f_addr); end
      checks++;
      m_pc = ref_next(m_pc, 32'h1000_FFFC, 1'b0, 1'b1, (pass == 0));
      do_fetch(32'h0, 0, 0, 1'b0, 1'b0, 1'b0);
      if (f_tmo || f_addr !== ((pass == 0) ? 32'h4 : 32'h14)) begin
        errors++; $display("FAIL beq_target_z%0d: got %h expected %h", (pass == 0), f_addr,
                           (pass == 0) ? 32'h4 : 32'h14);
      end
      checks++;
      m_pc = ref_next(m_pc, 32'h0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_jump();
    int unsigned n;
    h_rst_n = 1'b1;
    n = 0;
    while (h_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (h_addr !== 32'h2000_0000) begin errors++; $display("FAIL jump_fetch_addr: got %h expected 20000000", h_addr); end
    checks++;
    h_ack = 1'b1; h_rdata = 32'h0800_0040;
    @(negedge clk);
    h_ack = 1'b0; h_ready = 1'b1;
    @(negedge clk);
    h_ready = 1'b0; h_jump = 1'b1; h_branch = 1'b1; h_zero = 1'b1;
    @(negedge clk);
    h_jump = 1'b0; h_branch = 1'b0; h_zero = 1'b0;
    if (h_req !== 1'b1 || h_addr !== 32'h2000_0100) begin
      errors++; $display("FAIL jump_priority: got req=%b addr=%h expected 1/20000100", h_req, h_addr);
    end
    checks++;
  endtask

  task automatic test_ready_stall();
    logic [31:0] w;
    w = $urandom;
    do_fetch(w, 1, 3, 1'b0, 1'b0, 1'b0);
    if (f_tmo || f_addr !== m_pc) begin errors++; $display("FAIL stall_addr: got %h expected %h", f_addr, m_pc); end
    checks++;
    if (f_validc != 4 || !f_istab || f_instr !== w) begin
      errors++; $display("FAIL stall_hold: got %0d cycles stable=%0d instr=%h expected 4/1/%h",
                         f_validc, f_istab, f_instr, w);
    end
    checks++;
    m_pc = ref_next(m_pc, w, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] w;
    int unsigned ad, rd;
    logic j, b, z;
    for (int unsigned i = 0; i < 40; i++) begin
      w  = $urandom;
      ad = $urandom_range(0, 4);
      rd = $urandom_range(0, 3);
      j  = ($urandom_range(0, 3) == 0);
      b  = 1'($urandom);
      z  = 1'($urandom);
      do_fetch(w, ad, rd, j, b, z);
      if (f_tmo || f_addr !== m_pc || !f_astab || f_dup) begin
        errors++; $display("FAIL rand_addr[%0d]: got %h stable=%0d dup=%0d expected %h", i, f_addr, f_astab, f_dup, m_pc);
      end
      checks++;
      if (f_reqc != ad + 1) begin errors++; $display("FAIL rand_req_cycles[%0d]: got %0d expected %0d", i, f_reqc, ad + 1); end
      checks++;
      if (f_instr !== w || f_opc !== w[31:26] || !f_istab) begin
        errors++; $display("FAIL rand_instr[%0d]: got %h/%b expected %h/%b", i, f_instr, f_opc, w, w[31:26]);
      end
      checks++;
      if (f_validc != rd + 1) begin errors++; $display("FAIL rand_valid_cycles[%0d]: got %0d expected %0d", i, f_validc, rd + 1); end
      checks++;
      m_pc = ref_next(m_pc, w, j, b, z);
    end
  endtask

  task automatic test_reset_mid_wait();
    int unsigned n;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
`ifdef FETCH_TIMEOUT_EN
    repeat (3) @(negedge clk);
`else
    repeat (20) @(negedge clk);
    if (imem_req !== 1'b1 || fetch_fault !== 1'b0) begin
      errors++; $display("FAIL wait_forever: got req=%b fault=%b expected 1/0", imem_req, fetch_fault);
    end
    checks++;
`endif
    rst_n = 1'b0;
    #1;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || pc !== 32'h0) begin
      errors++; $display("FAIL async_reset: got req=%b valid=%b instr=%h pc=%h expected 0/0/0/0",
                         imem_req, instr_valid, instr, pc);
    end
    checks++;
    @(negedge clk);
    rst_n = 1'b1;
    m_pc  = 32'h0;
    do_fetch(32'h2000_0003, 0, 0, 1'b0, 1'b0, 1'b0);
    if (f_tmo || f_addr !== 32'h0) begin errors++; $display("FAIL refetch_addr: got %h expected 0", f_addr); end
    checks++;
    m_pc = ref_next(m_pc, 32'h2000_0003, 1'b0, 1'b0, 1'b0);
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    int unsigned n;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (imem_req === 1'b1 && n < 40) begin @(negedge clk); n++; end
    if (n != 16 || fetch_fault !== 1'b1 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL timeout_fault: got %0d cycles fault=%b expected 16/1", n, fetch_fault);
    end
    checks++;
    imem_ack = 1'b1;
    repeat (5) @(negedge clk);
    imem_ack = 1'b0;
    if (fetch_fault !== 1'b1 || imem_req !== 1'b0) begin
      errors++; $display("FAIL timeout_sticky: got fault=%b req=%b expected 1/0", fetch_fault, imem_req);
    end
    checks++;
    rst_n = 1'b0;
    #1;
    if (fetch_fault !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b expected 0", fetch_fault); end
    checks++;
    @(negedge clk);
    rst_n = 1'b1;
    m_pc  = 32'h0;
    do_fetch(32'h1234_5678, 15, 0, 1'b0, 1'b0, 1'b0);
    if (f_tmo || f_reqc != 16 || fetch_fault !== 1'b0 || f_validc != 1) begin
      errors++; $display("FAIL timeout_ack_wins: got %0d cycles fault=%b valid=%0d expected 16/0/1",
                         f_reqc, fetch_fault, f_validc);
    end
    checks++;
    m_pc = ref_next(m_pc, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    jump = 1'b0; branch = 1'b0; zero = 1'b0;
    h_rst_n = 1'b0; h_ack = 1'b0; h_rdata = '0; h_ready = 1'b0;
    h_jump = 1'b0; h_branch = 1'b0; h_zero = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_ack_delay();
    test_branch();
    test_jump();
    test_ready_stall();
    test_random();
    test_reset_mid_wait();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
